serial_lut_bank: RTL and testbench
==================================

Name: serial_lut_bank

Overview:
Bank of NUM_TABLES serially loaded lookup tables, each 2**IN_WIDTH entries of OUT_WIDTH bits. A framed serial load writes a shadow register. Only a complete, correctly sized frame commits it to the addressed table, so a partial or errant load never corrupts live contents. Lookup is registered with 1-cycle latency. This is the multi-table, double-buffered, error-checked successor to the single serial-load LUT.

Parameters:
IN_WIDTH, 3, entry-select width; table depth = 2**IN_WIDTH.
OUT_WIDTH, 4, entry width.
NUM_TABLES, 2, number of tables (>=2).
Derived: TBL_W = clog2(NUM_TABLES); TABLE_BITS = 2**IN_WIDTH*OUT_WIDTH; F = TBL_W + TABLE_BITS (+1 with LUT_PARITY_EN).

Ports:
clk  input  1  system clock, all logic on posedge.
rst  input  1  asynchronous, active-high reset.
d  input  1  serial load data, sampled on posedge when cs_n=0.
cs_n  input  1  load frame enable, active low, synchronous to clk.
tbl_sel  input  TBL_W  table used for lookup.
sel  input  IN_WIDTH  entry used for lookup.
out  output  OUT_WIDTH  registered lookup result.
load_done  output  1  1-cycle pulse: frame committed.
load_err  output  1  1-cycle pulse: frame rejected.
busy  output  1  high while a frame is in progress (state SHIFT).

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset: all tables, shadow, bit counter, out, load_done, load_err and busy go to 0. State goes to IDLE. Reset mid-frame discards the frame with no pulse.
- State IDLE: cs_n=0 samples the first bit, sets count=1 and moves to SHIFT. busy is registered and goes high on the cycle after that first sampled bit.
- State SHIFT: each cycle with cs_n=0 shifts d into the shadow LSB (shadow <= {shadow[F-2:0], d}). count increments and saturates at F+1.
- SHIFT exit: the first cycle with cs_n=1 returns to IDLE and evaluates the frame. No bit is sampled that cycle.
  - count==F: table[idx] <= data field and load_done=1 on the next cycle.
  - count!=F (short or overrun): load_err=1 and no table changes.
  - idx>=NUM_TABLES: load_err=1 and no commit.
- Frame layout, first bit first: idx (TBL_W bits, MSB first), then data (TABLE_BITS bits, MSB first), then parity bit if enabled.
- Data mapping: entry i = data[(i+1)*OUT_WIDTH-1 -: OUT_WIDTH]. The last OUT_WIDTH bits shifted are entry 0.
- Back-to-back frames: cs_n must be high for at least 1 cycle between frames. A 1-cycle gap is sufficient.
- Lookup: out <= table[tbl_sel][sel] every cycle, giving 1-cycle latency. Lookup runs during loads and is unaffected by shadow contents.
- tbl_sel>=NUM_TABLES: out <= 0.
- Commit and lookup in the same cycle on the same table: out shows the pre-commit value that cycle and the new value from the following cycle.
- load_done and load_err are mutually exclusive and never asserted for more than 1 cycle.

Optional Feature:
Macro LUT_PARITY_EN.
- Defined: the frame carries 1 trailing parity bit, so F grows by 1. Even parity is computed over idx+data+parity. A parity mismatch with count==F produces load_err and no commit.
- Undefined: no parity bit. F = TBL_W + TABLE_BITS and the parity logic is absent.

Test Plan:
All scenarios use defaults: F=33, no parity.
1. Reset then tbl_sel=0, sel=5 -> out=0 after 1 cycle. busy, load_done and load_err are all 0.
2. Frame idx=1, data=32'h76543210 (33 bits), then cs_n=1 -> load_done pulse 1 cycle after cs_n rises. Then tbl_sel=1, sel=k gives out=k for k=0..7, and table 0 still reads 0.
3. Frame of 20 bits, then cs_n=1 -> load_err pulse, no load_done. Table 1 still reads 32'h76543210 contents.
4. Frame of 40 bits -> load_err, no commit. A following valid frame idx=0, data=32'hFFFFFFFF after a 1-cycle gap -> load_done, and table 0 sel=3 reads 4'hF.
5. rst asserted at bit 17 of a frame -> everything zeroed immediately. After release, a fresh 33-bit frame commits normally.
6. Hold tbl_sel=1, sel=2 while committing table 1 data=32'hAAAAAAAA -> out=2 on the commit cycle, out=4'hA on the next. With LUT_PARITY_EN, a corrupt parity bit -> load_err and the table is unchanged.

Source files
------------

// File: rtl/serial_lut_bank.sv
// Bank of serially loaded lookup tables with a shadow register: only a complete frame commits.
// Define LUT_PARITY_EN to append an even-parity bit to each frame.
module serial_lut_bank #(
   parameter int unsigned IN_WIDTH   = 3,
   parameter int unsigned OUT_WIDTH  = 4,
   parameter int unsigned NUM_TABLES = 2,
   localparam int unsigned TBL_W     = $clog2(NUM_TABLES)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 d,
   input  logic                 cs_n,
   input  logic [TBL_W-1:0]     tbl_sel,
   input  logic [IN_WIDTH-1:0]  sel,
   output logic [OUT_WIDTH-1:0] out,
   output logic                 load_done,
   output logic                 load_err,
   output logic                 busy
);

   localparam int unsigned DEPTH      = 2 ** IN_WIDTH;
   localparam int unsigned TABLE_BITS = DEPTH * OUT_WIDTH;
`ifdef LUT_PARITY_EN
   localparam int unsigned PAR_W      = 1;
`else
   localparam int unsigned PAR_W      = 0;
`endif
   localparam int unsigned F          = TBL_W + TABLE_BITS + PAR_W;
   localparam int unsigned CNT_W      = $clog2(F + 2);
   localparam logic [TBL_W:0] NTAB    = (TBL_W + 1)'(NUM_TABLES);

   typedef enum logic [0:0] {StIdle, StShift} state_e;

   state_e                                 state_q;
   logic [F-1:0]                           shadow_q;
   logic [CNT_W-1:0]                       count_q;
   logic [DEPTH-1:0][OUT_WIDTH-1:0]        tbl_q [NUM_TABLES];
   logic [OUT_WIDTH-1:0]                   out_q, out_d;
   logic                                   load_done_q, load_err_q, busy_q;

   logic [TBL_W-1:0]                       frame_idx;
   logic [DEPTH-1:0][OUT_WIDTH-1:0]        frame_data;
   logic                                   parity_ok;
   logic                                   frame_ok;

   // Fields are only meaningful when exactly F bits were shifted in.
   assign frame_idx  = shadow_q[F-1 -: TBL_W];
   assign frame_data = shadow_q[F-1-TBL_W -: TABLE_BITS];

`ifdef LUT_PARITY_EN
   assign parity_ok = ~(^shadow_q);
`else
   assign parity_ok = 1'b1;
`endif

   assign frame_ok = (count_q == CNT_W'(F)) && ({1'b0, frame_idx} < NTAB) && parity_ok;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         shadow_q    <= '0;
         count_q     <= '0;
         load_done_q <= 1'b0;
         load_err_q  <= 1'b0;
         busy_q      <= 1'b0;
         for (int i = 0; i < NUM_TABLES; i++) begin
            tbl_q[i] <= '0;
         end
      end else begin
         load_done_q <= 1'b0;
         load_err_q  <= 1'b0;
         case (state_q)
            StIdle: begin
               if (!cs_n) begin
                  shadow_q <= {shadow_q[F-2:0], d};
                  count_q  <= CNT_W'(1);
                  state_q  <= StShift;
                  busy_q   <= 1'b1;
               end
            end
            StShift: begin
               if (!cs_n) begin
                  shadow_q <= {shadow_q[F-2:0], d};
                  // Saturate one past F so overruns stay distinguishable from exact frames.
                  if (count_q != CNT_W'(F + 1)) begin
                     count_q <= count_q + CNT_W'(1);
                  end
               end else begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
                  if (frame_ok) begin
                     tbl_q[frame_idx] <= frame_data;
                     load_done_q      <= 1'b1;
                  end else begin
                     load_err_q <= 1'b1;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   always_comb begin
      out_d = '0;
      if ({1'b0, tbl_sel} < NTAB) begin
         out_d = tbl_q[tbl_sel][sel];
      end
   end

   // Reads the pre-commit table contents on a commit edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q <= '0;
      end else begin
         out_q <= out_d;
      end
   end

   assign out       = out_q;
   assign load_done = load_done_q;
   assign load_err  = load_err_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_serial_lut_bank.sv
// Directed bench for serial_lut_bank: table-driven lookups plus hand-written load sequences.
module tb_serial_lut_bank;

`ifdef LUT_PARITY_EN
   localparam int FL = 34;
`else
   localparam int FL = 33;
`endif

   logic       clk = 1'b0;
   logic       rst, d, cs_n;
   logic [0:0] tbl_sel;
   logic [2:0] sel;
   logic [3:0] out;
   logic       load_done, load_err, busy;

   int   checks = 0;
   int   errors = 0;
   logic busy_first;

   typedef struct {
      logic       tsel;
      logic [2:0] sel;
      logic [3:0] exp;
   } vec_t;

   vec_t vecs [12];

   always #5 clk = ~clk;

   serial_lut_bank dut (
      .clk       (clk),
      .rst       (rst),
      .d         (d),
      .cs_n      (cs_n),
      .tbl_sel   (tbl_sel),
      .sel       (sel),
      .out       (out),
      .load_done (load_done),
      .load_err  (load_err),
      .busy      (busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] mk_frame(input logic idx, input logic [31:0] data);
`ifdef LUT_PARITY_EN
      return {30'b0, idx, data, ^{idx, data}};
`else
      return {31'b0, idx, data};
`endif
   endfunction

   // Shifts n bits MSB first, then raises cs_n for one edge (the evaluation edge).
   task automatic send(input logic [63:0] fr, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         cs_n = 1'b0;
         d    = fr[i];
         tick();
         if (i == n - 1) busy_first = busy;
      end
      cs_n = 1'b1;
      d    = 1'b0;
      tick();
   endtask

   task automatic run_vecs(input string tag);
      for (int i = 0; i < 12; i++) begin
         tbl_sel = vecs[i].tsel;
         sel     = vecs[i].sel;
         tick();
         check($sformatf("%s_t%0d_s%0d", tag, vecs[i].tsel, vecs[i].sel), out, vecs[i].exp);
      end
   endtask

   initial begin
      logic [63:0] fr;

      for (int k = 0; k < 8; k++) begin
         vecs[k] = '{tsel: 1'b1, sel: 3'(k), exp: 4'(k)};
      end
      vecs[8]  = '{tsel: 1'b0, sel: 3'd0, exp: 4'h0};
      vecs[9]  = '{tsel: 1'b0, sel: 3'd5, exp: 4'h0};
      vecs[10] = '{tsel: 1'b0, sel: 3'd7, exp: 4'h0};
      vecs[11] = '{tsel: 1'b0, sel: 3'd3, exp: 4'h0};

      // 1: reset state
      rst = 1'b1; cs_n = 1'b1; d = 1'b0; tbl_sel = 1'b0; sel = 3'd5;
      tick(); tick();
      rst = 1'b0;
      tick();
      check("rst_out", out, 0);
      check("rst_busy", busy, 0);
      check("rst_done", load_done, 0);
      check("rst_err", load_err, 0);

      // 2: valid frame into table 1
      send(mk_frame(1'b1, 32'h76543210), FL);
      check("t2_busy_first", busy_first, 1);
      check("t2_done", load_done, 1);
      check("t2_err", load_err, 0);
      check("t2_busy_end", busy, 0);
      tick();
      check("t2_done_pulse", load_done, 0);
      run_vecs("t2");

      // 3: short frame
      send(64'hABCDE, 20);
      check("t3_err", load_err, 1);
      check("t3_done", load_done, 0);
      tick();
      check("t3_err_pulse", load_err, 0);
      run_vecs("t3");

      // 4: overrun frame, then a valid frame after a 1-cycle gap
      send(64'h12_3456_789A, 40);
      check("t4_err", load_err, 1);
      check("t4_done0", load_done, 0);
      send(mk_frame(1'b0, 32'hFFFFFFFF), FL);
      check("t4_done", load_done, 1);
      check("t4_err1", load_err, 0);
      tbl_sel = 1'b0; sel = 3'd3;
      tick();
      check("t4_t0_s3", out, 4'hF);
      tbl_sel = 1'b1; sel = 3'd7;
      tick();
      check("t4_t1_s7", out, 4'h7);

      // 5: reset in the middle of a frame
      tbl_sel = 1'b0; sel = 3'd3;
      fr = mk_frame(1'b1, 32'h13579BDF);
      for (int i = 0; i < 17; i++) begin
         cs_n = 1'b0;
         d    = fr[FL-1-i];
         tick();
      end
      check("t5_busy_mid", busy, 1);
      check("t5_out_pre", out, 4'hF);
      #2;
      rst = 1'b1; cs_n = 1'b1;
      #1;
      check("t5_out_async", out, 0);
      check("t5_busy_async", busy, 0);
      check("t5_done_async", load_done, 0);
      check("t5_err_async", load_err, 0);
      tick();
      rst = 1'b0;
      tick();
      check("t5_t0_s3", out, 0);
      tbl_sel = 1'b1; sel = 3'd5;
      tick();
      check("t5_t1_s5", out, 0);
      send(mk_frame(1'b1, 32'h76543210), FL);
      check("t5_done", load_done, 1);
      check("t5_err", load_err, 0);
      sel = 3'd6;
      tick();
      check("t5_t1_s6", out, 4'h6);

      // 6: commit and lookup on the same table in the same cycle
      sel = 3'd2;
      tick();
      check("t6_pre", out, 4'h2);
      send(mk_frame(1'b1, 32'hAAAAAAAA), FL);
      check("t6_done", load_done, 1);
      check("t6_commit_cycle", out, 4'h2);
      tick();
      check("t6_next_cycle", out, 4'hA);

`ifdef LUT_PARITY_EN
      send(mk_frame(1'b0, 32'h12345678) ^ 64'd1, FL);
      check("par_err", load_err, 1);
      check("par_done", load_done, 0);
      tbl_sel = 1'b0; sel = 3'd3;
      tick();
      check("par_t0_s3", out, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
